// File: rtl/fifo_pkg.sv
// Shared widths, default watermark levels and parameter sanity checks
// for the parametrised FIFO controller and its storage.
package fifo_pkg;

  // Pointer width: enough bits to address every entry.
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Count width: one extra bit so that a completely full FIFO is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Default threshold constants derived from the depth.
  function automatic int half_level(input int depth);
    return depth / 2;
  endfunction

  function automatic int af_default(input int depth);
    return (depth * 3) / 4;
  endfunction

  function automatic int ae_default(input int depth);
    return depth / 4;
  endfunction

  // Depth must be a power of two (natural pointer wrap) and at least 4;
  // the watermarks must be ordered and reachable.
  function automatic bit params_ok(input int depth, input int ae, input int af);
    return (depth >= 4) && ((depth & (depth - 1)) == 0) && (ae < af) && (af <= depth);
  endfunction

endpackage

// File: rtl/fifo_ctrl_param_if.sv
// Producer/consumer side of the FIFO controller: write/read requests,
// read data, occupancy flags and sticky error status.
interface fifo_ctrl_param_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [DATA_W-1:0] data;
  logic              write;
  logic              read;
  logic              clr_err;
  logic [DATA_W-1:0] out;
  logic              out_valid;
  logic              empty;
  logic              full;
  logic              half_full;
  logic              three_quarter_full;
  logic              almost_empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  modport master (
    output data, write, read, clr_err,
    input  out, out_valid, empty, full, half_full, three_quarter_full,
           almost_empty, count, overflow, underflow
  );

  modport slave (
    input  data, write, read, clr_err,
    output out, out_valid, empty, full, half_full, three_quarter_full,
           almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port RAM: synchronous write port, registered read port.
// Only the read register is reset; the array contents are not.
module fifo_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_data_d;

  // Store the incoming word when the controller accepts a write.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Fetch a new word on an accepted read, otherwise hold the last one.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem_q[rd_addr];
    end
  end

  // Read data register; cleared by reset so the output starts at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_ctrl_param.sv
// Parametrised synchronous FIFO controller: pointers, occupancy count,
// watermark flags and sticky overflow/underflow around a dual-port RAM.
module fifo_ctrl_param
  import fifo_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 16,
  parameter int AE_LEVEL = ae_default(DEPTH),
  parameter int AF_LEVEL = af_default(DEPTH)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  fifo_ctrl_param_if.slave                        bus
);

  localparam int PTR_W      = ptr_w(DEPTH);
  localparam int CNT_W      = cnt_w(DEPTH);
  localparam int HALF_LEVEL = half_level(DEPTH);

  if (!params_ok(DEPTH, AE_LEVEL, AF_LEVEL)) begin : g_bad_params
    $error("fifo_ctrl_param: DEPTH must be a power of two >= 4 and AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             is_empty, is_full;
  logic             wr_ok, rd_ok;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNT_W'(DEPTH));
  assign wr_ok    = bus.write & ~is_full;
  assign rd_ok    = bus.read & ~is_empty;

  // Next-state for pointers, occupancy, read strobe and sticky errors;
  // an error event in the same cycle as clr_err keeps the flag set.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = rd_ok;
    overflow_d  = bus.clr_err ? 1'b0 : overflow_q;
    underflow_d = bus.clr_err ? 1'b0 : underflow_q;

    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (bus.write & is_full) begin
      overflow_d = 1'b1;
    end
    if (bus.read & is_empty) begin
      underflow_d = 1'b1;
    end
  end

  // Controller state register; reset discards everything stored.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr_q),
    .wr_data (bus.data),
    .rd_en   (rd_ok),
    .rd_addr (rd_ptr_q),
    .rd_data (bus.out)
  );

  assign bus.out_valid          = out_valid_q;
  assign bus.count              = count_q;
  assign bus.empty              = is_empty;
  assign bus.full               = is_full;
  assign bus.half_full          = (count_q >= CNT_W'(HALF_LEVEL));
  assign bus.three_quarter_full = (count_q >= CNT_W'(AF_LEVEL));
  assign bus.almost_empty       = (count_q <= CNT_W'(AE_LEVEL));
  assign bus.overflow           = overflow_q;
  assign bus.underflow          = underflow_q;

endmodule

// File: tb/tb_fifo_ctrl_param.sv
// Scoreboard bench for fifo_ctrl_param (DATA_W=32, DEPTH=16): stimulus
// pushes expected read words, a negedge monitor pops and compares them.
module tb_fifo_ctrl_param;

  logic clk = 1'b0;
  logic rst;

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 1'b0;

  logic [31:0] m_q   [$];
  logic [31:0] exp_q [$];
  bit          m_ov;
  bit          m_un;

  fifo_ctrl_param_if #(.DATA_W(32), .DEPTH(16)) bus ();

  fifo_ctrl_param #(.DATA_W(32), .DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Generic compare that feeds the pass/total counters.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare count, flags and sticky errors against a hand-given occupancy.
  task automatic checkState(input string name, input int cnt, input bit ov, input bit un);
    logic [11:0] act;
    logic [11:0] exp;
    act = {bus.count, bus.empty, bus.full, bus.half_full, bus.three_quarter_full,
           bus.almost_empty, bus.overflow, bus.underflow};
    exp = {5'(cnt), cnt == 0, cnt == 16, cnt >= 8, cnt >= 12, cnt <= 4, ov, un};
    checkOutput(name, 64'(act), 64'(exp));
  endtask

  // Drive one cycle of requests, update the reference queue, and return
  // just after the following falling edge with post-edge state visible.
  task automatic applyStimulus(input bit w, input bit r, input logic [31:0] d,
                               input bit c, input bit rs);
    int pre;
    pre         = m_q.size();
    bus.write   = w;
    bus.read    = r;
    bus.data    = d;
    bus.clr_err = c;
    rst         = rs;
    if (rs) begin
      m_q.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
    end else begin
      if (r && pre > 0) exp_q.push_back(m_q.pop_front());
      if (w && pre < 16) m_q.push_back(d);
      if (c) begin
        m_ov = 1'b0;
        m_un = 1'b0;
      end
      if (w && pre == 16) m_ov = 1'b1;
      if (r && pre == 0) m_un = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    bus.write   = 1'b0;
    bus.read    = 1'b0;
    bus.clr_err = 1'b0;
    rst         = 1'b0;
  endtask

  // Monitor: every out_valid pulse must match the oldest expected word,
  // and every expected word must appear on the cycle after its read.
  always @(negedge clk) begin
    if (mon_en && (bus.out_valid || exp_q.size() > 0)) begin
      if (!bus.out_valid) begin
        n_checks++;
        $display("[TB] FAIL read_missing: out_valid 0 expected 1 (word 0x%0h)", exp_q[0]);
        void'(exp_q.pop_front());
      end else if (exp_q.size() == 0) begin
        n_checks++;
        $display("[TB] FAIL read_unexpected: out_valid 1 with out 0x%0h, expected no output", bus.out);
      end else begin
        checkOutput("read_data", 64'(bus.out), 64'(exp_q.pop_front()));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt_tbl [4];
    cnt_tbl = '{2, 1, 0, 0};
    bus.data = '0; bus.write = 1'b0; bus.read = 1'b0; bus.clr_err = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1;

    // Reset for two cycles.
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    mon_en = 1'b1;
    checkState("reset_state", 0, 0, 0);
    checkOutput("reset_out", 64'(bus.out), 64'h0);
    checkOutput("reset_valid", 64'(bus.out_valid), 64'h0);

    // Test 1: three writes, four reads, last one underflows.
    applyStimulus(1, 0, 32'hABCD, 0, 0);
    applyStimulus(1, 0, 32'h1234, 0, 0);
    applyStimulus(1, 0, 32'h2345, 0, 0);
    checkState("t1_fill", 3, 0, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 0, 0, 0);
      checkState("t1_read", cnt_tbl[i], 0, i == 3);
    end
    checkOutput("t1_out_hold", 64'(bus.out), 64'h2345);
    checkOutput("t1_valid_low", 64'(bus.out_valid), 64'h0);
    applyStimulus(0, 0, 0, 1, 0);
    checkState("t1_clr", 0, 0, 0);

    // Test 2: 17 writes walk through every watermark, then drain.
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1, 0, 32'(i), 0, 0);
      checkState("t2_fill", (i < 16) ? i + 1 : 16, i == 16, 0);
    end
    for (int i = 0; i < 16; i++) applyStimulus(0, 1, 0, 0, 0);
    checkState("t2_drain", 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);

    // Test 3: concurrent read/write at count 5.
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 32'(100 + i), 0, 0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 1, 32'(200 + i), 0, 0);
      checkState("t3_rw", 5, 0, 0);
    end
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 0, 0);
    checkState("t3_drain", 0, 0, 0);

    // Test 4: read+write while full, then clr_err behaviour.
    for (int i = 0; i < 16; i++) applyStimulus(1, 0, 32'(300 + i), 0, 0);
    checkState("t4_full", 16, 0, 0);
    applyStimulus(1, 1, 32'hDEAD, 0, 0);
    checkState("t4_rw_full", 15, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkState("t4_clr", 15, 0, 0);
    applyStimulus(1, 0, 32'd400, 0, 0);
    applyStimulus(1, 0, 32'd401, 1, 0);
    checkState("t4_clr_vs_set", 16, 1, 0);
    for (int i = 0; i < 16; i++) applyStimulus(0, 1, 0, 0, 0);
    checkState("t4_drain", 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);

    // Test 5: stream with count oscillating 1..3, pointers wrap.
    applyStimulus(1, 0, 32'd500, 0, 0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 0, 32'(600 + 2 * i), 0, 0);
      applyStimulus(1, 0, 32'(601 + 2 * i), 0, 0);
      checkState("t5_high", 3, 0, 0);
      applyStimulus(0, 1, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0);
      checkState("t5_low", 1, 0, 0);
    end
    applyStimulus(0, 1, 0, 0, 0);
    checkState("t5_drain", 0, 0, 0);

    // Test 6: reset during an active read discards stored data.
    for (int i = 0; i < 10; i++) applyStimulus(1, 0, 32'(700 + i), 0, 0);
    checkState("t6_load", 10, 0, 0);
    applyStimulus(0, 1, 0, 0, 1);
    checkState("t6_reset", 0, 0, 0);
    checkOutput("t6_out", 64'(bus.out), 64'h0);
    checkOutput("t6_valid", 64'(bus.out_valid), 64'h0);
    applyStimulus(1, 0, 32'h5A5A, 0, 0);
    checkState("t6_write", 1, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    checkState("t6_read", 0, 0, 0);
    checkOutput("t6_new_word", 64'(bus.out), 64'h5A5A);

    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
